// File: rtl/hp_fp_add_dispatcher.sv
// Issue stage for the half-precision pipelined adder: queues operand pairs,
// drives the two-cycle start protocol and holds each sum in a result register.
module hp_fp_add_dispatcher #(
  parameter int FIFO_DEPTH     = 4,
  parameter int FLUSH_CYCLES   = 64,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_sum,
  output logic        res_inf,
  output logic        add_enable,
  output logic [15:0] add_in1,
  output logic [15:0] add_in2,
  input  logic        add_done,
  input  logic [15:0] add_sum,
  output logic        busy,
  output logic        err_timeout
);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (FLUSH_CYCLES > TIMEOUT_CYCLES) ? FLUSH_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] FLUSH_LOAD   = CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [AW:0]   PTR_ONE      = (AW + 1)'(1);

  typedef enum logic [2:0] {FLUSH, IDLE, ISSUE_A, ISSUE_B, WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [15:0]   a_q;
  logic [15:0]   b_q;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  // Pointers carry one extra wrap bit so equal indices can mean empty or full.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign op_ready = !full && !reset;
  assign push     = op_valid && op_ready;
  assign pop      = (state == IDLE) && !empty && (!res_valid || res_ready);

  assign add_in1 = a_q;
  assign add_in2 = b_q;
  assign busy    = (state != IDLE) || !empty || res_valid;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {op_a, op_b};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // One counter serves both the flush window and the WAIT timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FLUSH;
      cnt         <= FLUSH_LOAD;
      a_q         <= '0;
      b_q         <= '0;
      add_enable  <= 1'b0;
      res_valid   <= 1'b0;
      res_sum     <= '0;
      res_inf     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      add_enable <= 1'b0;
      if (res_valid && res_ready) res_valid <= 1'b0;
      case (state)
        FLUSH: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CNT_ONE;
        end
        IDLE: begin
          if (pop) begin
            {a_q, b_q} <= mem[rd_ptr[AW-1:0]];
            add_enable <= 1'b1;
            state      <= ISSUE_A;
          end
        end
        ISSUE_A: state <= ISSUE_B;
        ISSUE_B: begin
          cnt   <= TIMEOUT_LOAD;
          state <= WAIT;
        end
        WAIT: begin
          if (add_done) begin
            res_sum   <= add_sum;
            res_inf   <= &add_sum[14:10];
            res_valid <= 1'b1;
            state     <= IDLE;
          end else if (cnt == '0) begin
            err_timeout <= 1'b1;
            cnt         <= FLUSH_LOAD;
            state       <= FLUSH;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          cnt   <= FLUSH_LOAD;
          state <= FLUSH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hp_fp_add_dispatcher.sv
// Self-checking bench for hp_fp_add_dispatcher with a behavioural half-precision
// adder and a queue-based scoreboard built on real arithmetic.
module tb_hp_fp_add_dispatcher;
  localparam int FIFO_DEPTH     = 4;
  localparam int FLUSH_CYCLES   = 64;
  localparam int TIMEOUT_CYCLES = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_sum;
  logic        res_inf;
  logic        add_enable;
  logic [15:0] add_in1;
  logic [15:0] add_in2;
  logic        add_done = 1'b0;
  logic [15:0] add_sum = 16'h0000;
  logic        busy;
  logic        err_timeout;

  hp_fp_add_dispatcher #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_inf(res_inf),
    .add_enable(add_enable), .add_in1(add_in1), .add_in2(add_in2),
    .add_done(add_done), .add_sum(add_sum),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Half-precision arithmetic via exact reals and round-to-nearest-even.
  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp16ToReal(input logic [15:0] h);
    real v;
    if (h[14:10] == 5'd0) v = real'(int'(h[9:0])) * pow2(-24);
    else                  v = real'(int'(h[9:0]) + 1024) * pow2(int'(h[14:10]) - 25);
    return h[15] ? -v : v;
  endfunction

  function automatic int roundEven(input real x);
    int f;
    real r;
    f = $rtoi(x);
    r = x - real'(f);
    if (r > 0.5 || (r == 0.5 && f[0])) f++;
    return f;
  endfunction

  function automatic logic [15:0] realToFp16(input real v);
    logic s;
    real  mag;
    int   e;
    int   m;
    s   = (v < 0.0);
    mag = s ? -v : v;
    if (mag == 0.0) return 16'h0000;
    if (mag < pow2(-14)) begin
      m = roundEven(mag / pow2(-24));
      return {s, 15'(m)};
    end
    e = -14;
    while (e < 16 && mag >= pow2(e + 1)) e++;
    if (e > 15) return {s, 15'h7C00};
    m = roundEven(mag / pow2(e - 10));
    if (m == 2048) begin
      m = 1024;
      e++;
    end
    if (e > 15) return {s, 15'h7C00};
    return {s, 5'(e + 15), 10'(m - 1024)};
  endfunction

  function automatic logic [15:0] fp16Add(input logic [15:0] a, input logic [15:0] b);
    return realToFp16(fp16ToReal(a) + fp16ToReal(b));
  endfunction

  function automatic logic [15:0] randFp16();
    return {1'($urandom), 5'($urandom_range(0, 30)), 10'($urandom)};
  endfunction

  // Adder stand-in: in1 with enable, in2 next cycle, done high 7 cycles after enable.
  logic        hang = 1'b0;
  logic [15:0] m_a;
  logic [15:0] m_b;
  int          m_cnt = 0;

  always @(posedge clk) begin
    if (add_enable) begin
      m_a      <= add_in1;
      add_done <= 1'b0;
      m_cnt    <= 1;
    end else if (m_cnt != 0) begin
      if (m_cnt == 1) m_b <= add_in2;
      if (m_cnt == 6) begin
        if (!hang) begin
          add_done <= 1'b1;
          add_sum  <= fp16Add(m_a, m_b);
        end
        m_cnt <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Scoreboard: accepted pairs in order, expected sums of issued operations.
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } pair_t;

  pair_t       opq[$];
  logic [15:0] expq[$];
  logic        chk_b = 1'b0;
  logic [15:0] exp_b;
  logic        prev_en = 1'b0;
  logic        prev_hold = 1'b0;
  logic [15:0] prev_sum;
  int          n_enable = 0;
  int          n_results = 0;
  logic [15:0] last_sum;
  logic        last_inf;

  always @(negedge clk) begin
    if (reset) begin
      opq.delete();
      expq.delete();
      chk_b     <= 1'b0;
      prev_en   <= 1'b0;
      prev_hold <= 1'b0;
    end else begin
      if (chk_b) checkOutput("add_in2", add_in2, exp_b);
      chk_b <= 1'b0;
      if (add_enable) begin
        n_enable <= n_enable + 1;
        checkOutput("en_single_cycle", prev_en, 0);
        checkOutput("issue_has_op", opq.size() != 0, 1);
        if (opq.size() != 0) begin
          checkOutput("add_in1", add_in1, opq[0].a);
          exp_b <= opq[0].b;
          chk_b <= 1'b1;
          if (!hang) expq.push_back(fp16Add(opq[0].a, opq[0].b));
          void'(opq.pop_front());
        end
      end
      prev_en <= add_enable;
      if (prev_hold) begin
        checkOutput("hold_valid", res_valid, 1);
        checkOutput("hold_sum", res_sum, prev_sum);
      end
      prev_hold <= res_valid && !res_ready;
      prev_sum  <= res_sum;
      if (res_valid && res_ready) begin
        checkOutput("res_expected", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          checkOutput("res_sum", res_sum, expq[0]);
          checkOutput("res_inf", res_inf, expq[0][14:10] == 5'h1F);
          void'(expq.pop_front());
        end
        n_results <= n_results + 1;
        last_sum  <= res_sum;
        last_inf  <= res_inf;
      end
      if (op_valid && op_ready) opq.push_back({op_a, op_b});
    end
  end

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    logic acc;
    acc = 1'b0;
    op_a = a;
    op_b = b;
    op_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      acc = op_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    op_valid = 1'b0;
    if (!acc) checkOutput("push_accept", acc, 1);
  endtask

  task automatic waitIdle(input string tag);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkOutput({tag, "_idle"}, busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic waitResults(input int target, input string tag);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (n_results >= target) break;
    end
    checkOutput({tag, "_results"}, n_results, target);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   k;
    int   e0;
    int   r0;
    int   sent;
    int   others;
    logic acc;
    logic en_hist [1:10];
    logic rv_hist [1:10];

    op_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    res_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_op_ready", op_ready, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res_sum", res_sum, 0);
    checkOutput("rst_res_inf", res_inf, 0);
    checkOutput("rst_add_enable", add_enable, 0);
    checkOutput("rst_add_in1", add_in1, 0);
    checkOutput("rst_add_in2", add_in2, 0);
    checkOutput("rst_busy", busy, 1);
    checkOutput("rst_err_timeout", err_timeout, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // First IDLE exactly FLUSH_CYCLES cycles after the last reset edge.
    for (k = 0; k < FLUSH_CYCLES + 20; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkOutput("flush_len", k, FLUSH_CYCLES);
    checkOutput("flush_no_enable", n_enable, 0);
    @(posedge clk);
    #1;

    $display("[TB] single add");
    applyStimulus(16'h3C00, 16'h3C00);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      en_hist[c] = add_enable;
      rv_hist[c] = res_valid;
    end
    others = 0;
    for (int c = 1; c <= 10; c++) if (c != 2 && en_hist[c]) others++;
    checkOutput("single_en_c2", en_hist[2], 1);
    checkOutput("single_en_other", others, 0);
    checkOutput("single_rv_c9", rv_hist[9], 0);
    checkOutput("single_rv_c10", rv_hist[10], 1);
    checkOutput("single_sum", res_sum, 16'h4000);
    checkOutput("single_inf", res_inf, 0);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    waitIdle("single");

    $display("[TB] full fifo and backpressure");
    res_ready = 1'b0;
    e0 = n_enable;
    r0 = n_results;
    for (int i = 0; i < 5; i++) applyStimulus(16'h4000, 16'h3C00);
    repeat (20) @(negedge clk);
    checkOutput("bp_op_ready", op_ready, 0);
    checkOutput("bp_issues", n_enable - e0, 1);
    checkOutput("bp_res_valid", res_valid, 1);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (n_results - r0 >= 5) break;
    end
    checkOutput("bp_drained", n_results - r0, 5);
    checkOutput("bp_last_sum", last_sum, 16'h4200);
    waitIdle("bp");

    $display("[TB] zero and infinity");
    r0 = n_results;
    applyStimulus(16'h3C00, 16'hBC00);
    waitResults(r0 + 1, "zero");
    checkOutput("zero_sum", last_sum, 16'h0000);
    applyStimulus(16'h7BFF, 16'h7BFF);
    waitResults(r0 + 2, "inf");
    checkOutput("inf_exp", last_sum[14:10], 5'h1F);
    checkOutput("inf_flag", last_inf, 1);
    waitIdle("zi");

    $display("[TB] timeout");
    hang = 1'b1;
    e0 = n_enable;
    applyStimulus(16'h4000, 16'h4000);
    for (k = 1; k < 200; k++) begin
      @(negedge clk);
      if (err_timeout) break;
    end
    checkOutput("to_cycle", k, 4 + TIMEOUT_CYCLES);
    checkOutput("to_flush_busy", busy, 1);
    checkOutput("to_res_valid", res_valid, 0);
    checkOutput("to_issues", n_enable - e0, 1);
    @(posedge clk);
    #1;
    hang = 1'b0;
    waitIdle("to");
    r0 = n_results;
    applyStimulus(16'h3C00, 16'h4000);
    waitResults(r0 + 1, "to_recover");
    checkOutput("to_recover_sum", last_sum, 16'h4200);
    checkOutput("to_sticky", err_timeout, 1);
    waitIdle("to2");

    $display("[TB] reset mid-operation");
    applyStimulus(16'h4000, 16'h4000);
    applyStimulus(16'h3C00, 16'h3C00);
    applyStimulus(16'h4400, 16'h4400);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_op_ready", op_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    e0 = n_enable;
    r0 = n_results;
    @(negedge clk);
    checkOutput("mid_res_valid", res_valid, 0);
    checkOutput("mid_res_sum", res_sum, 0);
    checkOutput("mid_res_inf", res_inf, 0);
    checkOutput("mid_add_enable", add_enable, 0);
    checkOutput("mid_add_in1", add_in1, 0);
    checkOutput("mid_add_in2", add_in2, 0);
    checkOutput("mid_busy", busy, 1);
    checkOutput("mid_err_timeout", err_timeout, 0);
    for (k = 1; k < FLUSH_CYCLES + 20; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkOutput("mid_flush_len", k, FLUSH_CYCLES);
    checkOutput("mid_no_enable", n_enable - e0, 0);
    checkOutput("mid_no_stale", n_results - r0, 0);
    @(posedge clk);
    #1;
    applyStimulus(16'h4400, 16'h3C00);
    waitResults(r0 + 1, "mid_fresh");
    checkOutput("mid_fresh_sum", last_sum, 16'h4500);
    waitIdle("mid");

    $display("[TB] simultaneous events");
    res_ready = 1'b0;
    e0 = n_enable;
    r0 = n_results;
    applyStimulus(16'h3C00, 16'h3C00);
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    checkOutput("sim_first_valid", res_valid, 1);
    @(posedge clk);
    #1;
    applyStimulus(16'h4000, 16'h3C00);
    repeat (5) @(negedge clk);
    checkOutput("sim_stalled", n_enable - e0, 1);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    op_a = 16'h4400;
    op_b = 16'h4000;
    op_valid = 1'b1;
    @(negedge clk);
    checkOutput("sim_push_ready", op_ready, 1);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    @(negedge clk);
    checkOutput("sim_issue", add_enable, 1);
    checkOutput("sim_consumed", res_valid, 0);
    waitResults(r0 + 3, "sim");
    checkOutput("sim_issues", n_enable - e0, 3);
    checkOutput("sim_last_sum", last_sum, 16'h4600);
    waitIdle("sim");

    $display("[TB] randomized traffic");
    r0 = n_results;
    sent = 0;
    op_valid = 1'b0;
    for (int c = 0; c < 4000 && sent < 40; c++) begin
      @(negedge clk);
      acc = op_valid && op_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        op_valid = 1'b0;
        sent++;
      end
      if (!op_valid && sent < 40 && ($urandom % 2 == 0)) begin
        op_a = randFp16();
        op_b = randFp16();
        op_valid = 1'b1;
      end
      res_ready = ($urandom % 3) != 0;
    end
    op_valid = 1'b0;
    checkOutput("rand_sent", sent, 40);
    res_ready = 1'b1;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (n_results - r0 >= 40 && !busy) break;
    end
    checkOutput("rand_results", n_results - r0, 40);
    checkOutput("rand_sticky", err_timeout, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hp_fp_add_dispatcher.md
# hp_fp_add_dispatcher

Upstream issue stage for the half-precision pipelined adder. Buffers operand pairs from a valid/ready producer in a small FIFO and drives the adder's multi-cycle start protocol:
- `in1` is presented with `enable` for one cycle.
- `in2` is presented the following cycle.

It then waits for the adder's level `done`, captures `sum` into a single valid/ready result register, and flushes/recovers the adder after reset or a hang.

## Interface
- `FIFO_DEPTH`, default 4: operand-pair FIFO entries; power of two, at least 2.
- `FLUSH_CYCLES`, default 64: idle cycles after reset or timeout so the adder returns to its start state; at least 64.
- `TIMEOUT_CYCLES`, default 64: maximum WAIT cycles before aborting an operation.
- `clk`  in  1  sole clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `op_valid`  in  1  operand pair valid.
- `op_ready`  out  1  FIFO can accept.
- `op_a`  in  16  first operand (IEEE half).
- `op_b`  in  16  second operand.
- `res_valid`  out  1  result register full.
- `res_ready`  in  1  consumer accepts.
- `res_sum`  out  16  captured adder sum.
- `res_inf`  out  1  `res_sum[14:10] == 5'h1F`.
- `add_enable`  out  1  adder start strobe.
- `add_in1`  out  16  to adder `in1`.
- `add_in2`  out  16  to adder `in2`.
- `add_done`  in  1  adder `done` (level, cleared by adder on accepted start).
- `add_sum`  in  16  adder `sum`.
- `busy`  out  1  FSM not IDLE, or FIFO non-empty, or `res_valid`.
- `err_timeout`  out  1  sticky: a WAIT timeout occurred.

## Operation
- **FIFO:**
  - Entries are `{op_a, op_b}`; a push occurs when `op_valid && op_ready`.
  - `op_ready = !full`, and is forced to 0 while `reset` is high.
  - When full, `op_ready` is 0 even if a pop occurs in the same cycle.
  - Push and pop in the same cycle on a non-empty FIFO are both performed.
  - There is no bypass: a pushed entry is poppable from the next cycle.
  - Read and write pointers wrap modulo `FIFO_DEPTH`; an extra occupancy bit distinguishes full from empty.
- **Operand registers `a_q`, `b_q`:**
  - Loaded on pop.
  - `add_in1 = a_q` and `add_in2 = b_q` continuously; they change only on the next pop.
- **FSM states:** FLUSH, IDLE, ISSUE_A, ISSUE_B, WAIT.
  - **FLUSH:** down-counter loads `FLUSH_CYCLES-1`; at 0, go to IDLE. `add_enable = 0`. FIFO may accept pushes.
  - **IDLE:** if the FIFO is non-empty and (`!res_valid` or `res_ready`), pop into `a_q`/`b_q` and go to ISSUE_A.
  - **ISSUE_A:** `add_enable = 1` for exactly this cycle; go to ISSUE_B.
  - **ISSUE_B:** `add_enable = 0` (adder samples `add_in2`); load the timeout counter with `TIMEOUT_CYCLES-1`; go to WAIT.
  - **WAIT:**
    - If `add_done == 1`: capture `add_sum` into `res_sum` and compute `res_inf`, set `res_valid`, go to IDLE.
    - Else if the timeout counter is 0: set `err_timeout`, discard the operation, go to FLUSH.
    - Else decrement the counter.
  - A stale `add_done == 1` cannot be mis-sampled: the adder clears `done` at the ISSUE_A edge, before WAIT is entered.
- **Result register:**
  - `res_valid` clears on `res_valid && res_ready` unless a new capture occurs that same edge; capture has priority.
  - `res_sum` and `res_inf` are stable while `res_valid && !res_ready`.
- **`err_timeout`:** cleared only by `reset`.
- **Reset:**
  - Applies mid-operation from any state.
  - Empties the FIFO, drops the in-flight op and the result, and enters FLUSH.
  - The adder is not reset; FLUSH covers its worst-case completion.
- **Reset values:**
  - `op_ready = 0`, `res_valid = 0`, `res_sum = 0`, `res_inf = 0`.
  - `add_enable = 0`, `add_in1 = 0`, `add_in2 = 0`.
  - `busy = 1` (FSM is in FLUSH), `err_timeout = 0`.

## Timing
- Cycle n is the interval after posedge n.
- Pair pushed at the end of cycle 0, FSM in IDLE with an empty result path:
  - Pop at the end of cycle 1.
  - ISSUE_A in cycle 2 (`add_enable = 1`).
  - ISSUE_B in cycle 3.
  - WAIT from cycle 4.
- If `add_done` is first high in WAIT cycle d, `res_valid = 1` from cycle d+1.
- Back-to-back operations: the next pop can occur in cycle d+1 (IDLE) if the FIFO is non-empty and the result is consumed or the register is empty. The minimum issue spacing is therefore 4 cycles plus adder latency.
- `add_enable` is never high in two consecutive cycles, and never high outside ISSUE_A.
- First IDLE after reset deasserts: `FLUSH_CYCLES` cycles later.

## Test plan
- **Single add:** with the production adder attached after FLUSH, push `op_a = 0x3C00`, `op_b = 0x3C00` at cycle 0 → `add_enable` high in cycle 2 only, `res_valid` in cycle 10, `res_sum = 0x4000`, `res_inf = 0`.
- **Full FIFO and backpressure:** hold `res_ready = 0`, push 5 pairs (2.0+1.0 = `0x4000`+`0x3C00`, repeated) →
  - `op_ready` falls after the FIFO fills.
  - Exactly one operation issues; the FSM stalls in IDLE.
  - Raising `res_ready` drains all results, each `0x4200`, in order, with no loss or duplication.
- **Zero and infinity cases:**
  - `0x3C00 + 0xBC00` → `res_sum = 0x0000`.
  - `0x7BFF + 0x7BFF` → `res_sum[14:10] = 0x1F` and `res_inf = 1`.
- **Timeout:** replace the adder with a model that never raises `done`, push one pair → `err_timeout` set exactly `TIMEOUT_CYCLES` cycles after WAIT entry; the FSM enters FLUSH; `res_valid` stays 0; a later pair with the model fixed completes normally and `err_timeout` stays 1.
- **Reset mid-operation:** assert `reset` for 1 cycle while in WAIT with 2 pairs queued →
  - All outputs take their reset values next cycle, with `op_ready = 0` during reset.
  - No `add_enable` for `FLUSH_CYCLES` cycles; no stale result is delivered.
  - A fresh pair then completes correctly.
- **Simultaneous events:** push in the same cycle as an IDLE pop from a 1-entry FIFO, and capture in the same cycle as `res_ready` consumes the previous result → occupancy unchanged, `res_valid` stays 1 with the new sum.
